// File: rtl/tsg.sv
`default_nettype none
// ============================================================================
// Module   : tsg
// Brief    : Training-sequence generator; emits one 128-bit TS1/TS2 image per
//            TS period and flags when enough TSs have been sent.
// Revision : 1.0 - initial release
// ============================================================================
module tsg #(
    parameter int TS_PERIOD_G1    = 64,
    parameter int TS_PERIOD_G2    = 32,
    parameter int TX_NUM_POLL_ACT = 1024,
    parameter int TX_NUM_POLL_CFG = 16,
    parameter int TX_NUM_DEFAULT  = 16,
    parameter int CNT_W           = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   ts_info,
    input  logic         ts_update,
    output logic         ts_update_ack,
    input  logic         ts_stop,
    input  logic         speed,
    output logic         tx_ts_valid,
    output logic [127:0] tx_ts,
    output logic         ts_sent_enough
);

    localparam logic [7:0]       c_com             = 8'hBC;
    localparam logic [7:0]       c_padg12          = 8'hF7;
    localparam logic [7:0]       c_d10_2           = 8'h4A;
    localparam logic [7:0]       c_d5_2            = 8'h45;
    localparam logic [5:0]       c_rate_support    = 6'b000011;
    localparam logic [3:0]       c_st_poll         = 4'h2;
    localparam logic [3:0]       c_sub_poll_active = 4'h1;
    localparam logic [3:0]       c_sub_poll_cfg    = 4'h3;
    localparam logic [7:0]       c_g1_last         = 8'(TS_PERIOD_G1 - 1);
    localparam logic [7:0]       c_g2_last         = 8'(TS_PERIOD_G2 - 1);
    localparam logic [CNT_W-1:0] c_tgt_act         = CNT_W'(TX_NUM_POLL_ACT);
    localparam logic [CNT_W-1:0] c_tgt_cfg         = CNT_W'(TX_NUM_POLL_CFG);
    localparam logic [CNT_W-1:0] c_tgt_def         = CNT_W'(TX_NUM_DEFAULT);
    localparam logic [CNT_W-1:0] c_cnt_one         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max         = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_info, w_info_nxt;
    logic [127:0]     r_img, w_img_nxt, w_new_img;
    logic [7:0]       r_tmr, w_tmr_nxt;
    logic [7:0]       r_last, w_last_nxt, w_speed_last;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_target;
    logic             r_valid, w_valid_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_enough, w_enough_nxt;
    logic             w_accept, w_is_ts1;
    logic [7:0]       w_fill;

    assign w_accept     = ts_update & ~r_ack & ~ts_stop;
    assign w_speed_last = speed ? c_g2_last : c_g1_last;
    assign w_is_ts1     = (ts_info[3:0] == c_sub_poll_active) || (ts_info[7:4] != c_st_poll);
    assign w_fill       = w_is_ts1 ? c_d10_2 : c_d5_2;
    assign w_new_img    = {c_com, c_padg12, c_padg12, 8'hFF, 2'b00, c_rate_support,
                           8'h00, {10{w_fill}}};

    always_comb begin
        w_target = c_tgt_def;
        if (r_info == {c_st_poll, c_sub_poll_active}) begin
            w_target = c_tgt_act;
        end else if (r_info == {c_st_poll, c_sub_poll_cfg}) begin
            w_target = c_tgt_cfg;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_info_nxt   = r_info;
        w_img_nxt    = r_img;
        w_tmr_nxt    = r_tmr;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_valid_nxt  = 1'b0;
        w_ack_nxt    = 1'b0;
        w_enough_nxt = r_enough;
        if (w_accept) begin
            // The first TS leaves together with the ack, so it is already counted.
            w_state_nxt  = ST_SEND;
            w_info_nxt   = ts_info;
            w_img_nxt    = w_new_img;
            w_tmr_nxt    = 8'd0;
            w_last_nxt   = w_speed_last;
            w_cnt_nxt    = c_cnt_one;
            w_valid_nxt  = 1'b1;
            w_ack_nxt    = 1'b1;
            w_enough_nxt = 1'b0;
        end else if (r_state == ST_SEND) begin
            if (ts_stop) begin
                w_state_nxt  = ST_IDLE;
                w_tmr_nxt    = 8'd0;
                w_cnt_nxt    = '0;
                w_enough_nxt = 1'b0;
            end else begin
                if (r_cnt >= w_target) begin
                    w_enough_nxt = 1'b1;
                end
                // Period length is only re-sampled at a TS boundary.
                if (r_tmr == r_last) begin
                    w_tmr_nxt   = 8'd0;
                    w_last_nxt  = w_speed_last;
                    w_valid_nxt = 1'b1;
                    if (r_cnt != c_cnt_max) begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end else begin
                    w_tmr_nxt = r_tmr + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_info   <= 8'd0;
            r_img    <= '0;
            r_tmr    <= 8'd0;
            r_last   <= 8'd0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_ack    <= 1'b0;
            r_enough <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_info   <= w_info_nxt;
            r_img    <= w_img_nxt;
            r_tmr    <= w_tmr_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            r_valid  <= w_valid_nxt;
            r_ack    <= w_ack_nxt;
            r_enough <= w_enough_nxt;
        end
    end

    assign ts_update_ack  = r_ack;
    assign tx_ts_valid    = r_valid;
    assign tx_ts          = r_img;
    assign ts_sent_enough = r_enough;

endmodule
`default_nettype wire

// File: tb/tb_tsg.sv
`default_nettype none
// ============================================================================
// Module   : tb_tsg
// Brief    : Self-checking bench for tsg: vector table, directed corner cases
//            and random traffic against a time-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tsg;

    localparam int P1    = 64;
    localparam int P2    = 32;
    localparam int N_ACT = 40;
    localparam int N_CFG = 16;
    localparam int N_DEF = 12;
    localparam int CNT_W = 16;

    localparam logic [7:0] COM     = 8'hBC;
    localparam logic [7:0] PAD     = 8'hF7;
    localparam logic [7:0] D10_2   = 8'h4A;
    localparam logic [7:0] D5_2    = 8'h45;
    localparam logic [5:0] RATE    = 6'b000011;
    localparam logic [3:0] ST_DET  = 4'h1;
    localparam logic [3:0] ST_POLL = 4'h2;
    localparam logic [3:0] ST_CFG  = 4'h3;
    localparam logic [3:0] SUB_ACT = 4'h1;
    localparam logic [3:0] SUB_CMP = 4'h2;
    localparam logic [3:0] SUB_CFG = 4'h3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   ts_info = 8'd0;
    logic         ts_update = 1'b0;
    logic         ts_update_ack;
    logic         ts_stop = 1'b0;
    logic         speed = 1'b0;
    logic         tx_ts_valid;
    logic [127:0] tx_ts;
    logic         ts_sent_enough;

    always #5 clk = ~clk;

    tsg #(
        .TS_PERIOD_G1   (P1),
        .TS_PERIOD_G2   (P2),
        .TX_NUM_POLL_ACT(N_ACT),
        .TX_NUM_POLL_CFG(N_CFG),
        .TX_NUM_DEFAULT (N_DEF),
        .CNT_W          (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ts_info       (ts_info),
        .ts_update     (ts_update),
        .ts_update_ack (ts_update_ack),
        .ts_stop       (ts_stop),
        .speed         (speed),
        .tx_ts_valid   (tx_ts_valid),
        .tx_ts         (tx_ts),
        .ts_sent_enough(ts_sent_enough)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] img_of(input logic [7:0] info);
        logic [7:0] sym;
        sym = (info[3:0] == SUB_ACT || info[7:4] != ST_POLL) ? D10_2 : D5_2;
        return {COM, PAD, PAD, 8'hFF, 2'b00, RATE, 8'h00, {10{sym}}};
    endfunction

    function automatic int target_of(input logic [7:0] info);
        if (info == {ST_POLL, SUB_ACT}) return N_ACT;
        if (info == {ST_POLL, SUB_CFG}) return N_CFG;
        return N_DEF;
    endfunction

    function automatic int period_of(input logic s);
        return s ? P2 : P1;
    endfunction

    // Reference model: strobes are scheduled at absolute edge numbers.
    bit           m_active = 1'b0;
    logic         m_ack = 1'b0, m_valid = 1'b0, m_enough = 1'b0;
    logic [127:0] m_img = '0;
    int           m_target = 0, m_count = 0, m_next = 0, m_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_ack <= 1'b0; m_valid <= 1'b0; m_enough <= 1'b0;
            m_img <= '0; m_count <= 0; m_next <= 0; m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (ts_update && !m_ack && !ts_stop) begin
                m_active <= 1'b1; m_ack <= 1'b1; m_valid <= 1'b1; m_enough <= 1'b0;
                m_count  <= 1;
                m_img    <= img_of(ts_info);
                m_target <= target_of(ts_info);
                m_next   <= m_cyc + period_of(speed);
            end else if (ts_stop && m_active) begin
                m_active <= 1'b0; m_ack <= 1'b0; m_valid <= 1'b0;
                m_count  <= 0; m_enough <= 1'b0;
            end else begin
                m_ack   <= 1'b0;
                m_valid <= 1'b0;
                if (m_active) begin
                    if (m_count >= m_target) m_enough <= 1'b1;
                    if (m_cyc == m_next) begin
                        m_valid <= 1'b1;
                        m_count <= (m_count == (1 << CNT_W) - 1) ? m_count : m_count + 1;
                        m_next  <= m_cyc + period_of(speed);
                    end
                end
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid",  tx_ts_valid,    m_valid);
            chk("model_ack",    ts_update_ack,  m_ack);
            chk("model_enough", ts_sent_enough, m_enough);
            chk("model_image",  tx_ts,          m_img);
        end
    end

    task automatic wait_strobe(input string name, input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!tx_ts_valid && waited < budget);
        if (!tx_ts_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_to_enough(input string name, input int budget, input int n0,
                                 output int n, output int since);
        n = n0;
        since = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            since++;
            if (tx_ts_valid) begin
                n++;
                since = 0;
            end
            if (ts_sent_enough) break;
        end
        chk({name, "_rise"}, ts_sent_enough, 1);
    endtask

    task automatic accept(input logic [7:0] info, input logic spd);
        ts_info   = info;
        speed     = spd;
        ts_update = 1'b1;
        @(negedge clk);
        chk("accept_ack", ts_update_ack, 1);
        chk("accept_first_valid", tx_ts_valid, 1);
        ts_update = 1'b0;
    endtask

    typedef struct {
        logic [7:0] info;
        logic [7:0] fill;
        int         target;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, since, w, strobes, acks;
        logic [7:0]   fill_w;
        logic [79:0]  tail;

        tbl[0] = '{info: {ST_POLL, SUB_ACT}, fill: D10_2, target: N_ACT};
        tbl[1] = '{info: {ST_POLL, SUB_CFG}, fill: D5_2,  target: N_CFG};
        tbl[2] = '{info: {ST_POLL, SUB_CMP}, fill: D5_2,  target: N_DEF};
        tbl[3] = '{info: {ST_POLL, 4'h0},    fill: D5_2,  target: N_DEF};
        tbl[4] = '{info: {ST_DET,  SUB_ACT}, fill: D10_2, target: N_DEF};
        tbl[5] = '{info: {ST_CFG,  SUB_CFG}, fill: D10_2, target: N_DEF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_valid",  tx_ts_valid, 0);
        chk("reset_ack",    ts_update_ack, 0);
        chk("reset_enough", ts_sent_enough, 0);
        chk("reset_image",  tx_ts, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // POLL_ACTIVE at Gen1: TS1 image, 64-cycle spacing, enough after N_ACT strobes
        accept({ST_POLL, SUB_ACT}, 1'b0);
        tail = {10{D10_2}};
        chk("act_sym0", tx_ts[127:120], COM);
        chk("act_sym6_15", tx_ts[79:0], tail);
        wait_strobe("act_gap", 200, w);
        chk("act_gap", w, P1);
        run_to_enough("act_enough", P1 * N_ACT + 200, 2, n, since);
        chk("act_enough_count", n, N_ACT);
        chk("act_enough_lag", since, 1);

        // Update to POLL_CFG at Gen2 while enough is high
        accept({ST_POLL, SUB_CFG}, 1'b1);
        tail = {10{D5_2}};
        chk("cfg_enough_cleared", ts_sent_enough, 0);
        chk("cfg_sym6_15", tx_ts[79:0], tail);
        wait_strobe("cfg_gap", 200, w);
        chk("cfg_gap", w, P2);
        run_to_enough("cfg_enough", P2 * N_CFG + 200, 2, n, since);
        chk("cfg_enough_count", n, N_CFG);
        chk("cfg_enough_lag", since, 1);

        // Speed change mid-period finishes the current 64-cycle TS
        accept({ST_CFG, 4'h0}, 1'b0);
        repeat (20) @(negedge clk);
        speed = 1'b1;
        wait_strobe("toggle_gap1", 200, w);
        chk("toggle_gap1", w + 20, P1);
        wait_strobe("toggle_gap2", 200, w);
        chk("toggle_gap2", w, P2);

        // Stop and update together: stop wins, image retained, then accept
        repeat (5) @(negedge clk);
        ts_info   = {ST_POLL, SUB_ACT};
        ts_update = 1'b1;
        ts_stop   = 1'b1;
        strobes = 0;
        acks = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx_ts_valid) strobes++;
            if (ts_update_ack) acks++;
        end
        chk("stop_no_strobes", strobes, 0);
        chk("stop_no_ack", acks, 0);
        chk("stop_image_kept", tx_ts, img_of({ST_CFG, 4'h0}));
        ts_stop = 1'b0;
        @(negedge clk);
        chk("stop_release_ack", ts_update_ack, 1);
        chk("stop_release_valid", tx_ts_valid, 1);
        chk("stop_release_image", tx_ts, img_of({ST_POLL, SUB_ACT}));
        ts_update = 1'b0;

        // Asynchronous reset between edges mid-SEND
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_valid",  tx_ts_valid, 0);
        chk("areset_ack",    ts_update_ack, 0);
        chk("areset_enough", ts_sent_enough, 0);
        chk("areset_image",  tx_ts, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (tx_ts_valid) strobes++;
        end
        chk("areset_no_strobes", strobes, 0);

        // Vector table: image and target for each state/substate
        for (int i = 0; i < 6; i++) begin
            accept(tbl[i].info, 1'b1);
            fill_w = tbl[i].fill;
            chk($sformatf("tbl%0d_image", i), tx_ts,
                {COM, PAD, PAD, 8'hFF, 2'b00, RATE, 8'h00, {10{fill_w}}});
            run_to_enough($sformatf("tbl%0d_enough", i), P2 * tbl[i].target + 200, 1, n, since);
            chk($sformatf("tbl%0d_target", i), n, tbl[i].target);
        end

        // Random traffic checked cycle by cycle against the model
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (ts_update && ts_update_ack)
                ts_update = ($urandom_range(0, 7) == 0);
            else if (!ts_update && $urandom_range(0, 599) == 0) begin
                ts_update = 1'b1;
                ts_info   = tbl[$urandom_range(0, 5)].info;
            end
            ts_stop = ($urandom_range(0, 499) == 0) || (ts_stop && $urandom_range(0, 1) == 0);
            if ($urandom_range(0, 99) == 0) speed = ~speed;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
